overlap_buffer: RTL

Parametrised overlapping-frame sample buffer for the audio STFT path. It accepts a continuous AXI-stream of samples and emits frames of `FRAME_LEN` samples, with successive frames starting `HOP` samples apart. Writes and reads run concurrently. The output fully honours downstream backpressure across the block-RAM read latency. It sits between the audio input stream and the windowing/FFT stage.

---
 rtl/overlap_buffer_pkg.sv | 12 +
 rtl/overlap_buffer_if.sv | 11 +
 rtl/overlap_buffer_sdp_ram.sv | 24 ++
 rtl/overlap_buffer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/overlap_buffer_pkg.sv
// Shared types and constants for the overlapping-frame sample buffer.
package audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } overlap_state_t;

    localparam int OVB_FIFO_DEPTH = 4;
    localparam int RAM_LATENCY    = 2;

endpackage

// File: rtl/overlap_buffer_if.sv
// Valid/ready/data stream bundle used for the sample input and frame output.
interface Axis_If #(
    parameter int DATA_WIDTH = 24
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/overlap_buffer_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with a two-stage registered read.
module sdp_ram #(
    parameter int WIDTH      = 24,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_stage_reg;

    // Second stage runs unconditionally; the caller tracks which cycles carry valid data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_stage_reg <= mem[rd_addr];
        rd_data <= rd_stage_reg;
    end
endmodule

// File: rtl/overlap_buffer.sv
// Overlapping-frame buffer: emits FRAME_LEN-sample frames every HOP input samples.
// Optional OVERLAP_BUFFER_STATS_EN adds saturating frame_count / stall_count outputs.
module overlap_buffer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FRAME_LEN  = 1024,
    parameter int HOP        = 512
) (
    input  logic   clk,
    input  logic   reset_n,
    Axis_If.Slave  din,
    Axis_If.Master dout,
    output logic   dout_last
`ifdef OVERLAP_BUFFER_STATS_EN
    ,
    output logic [31:0] frame_count,
    output logic [31:0] stall_count
`endif
);
    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int IW    = $clog2(FRAME_LEN);
    localparam int FW    = $clog2(OVB_FIFO_DEPTH);
    localparam int CW    = FW + 1;

    overlap_state_t        state_reg;
    logic [PW-1:0]         wr_ptr_reg, base_reg;
    logic [PW-1:0]         wr_ptr_next, base_next, occ, occ_next, rd_ptr;
    logic [IW-1:0]         rd_idx_reg;
    logic                  din_ready_reg;
    logic                  wr_en, issue, frame_end, credit_ok, push, pop;
    logic [CW-1:0]         inflight, credit_used, fifo_count_reg;
    logic [RAM_LATENCY-1:0] pipe_valid_reg, pipe_last_reg;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] fifo_data_reg [OVB_FIFO_DEPTH];
    logic [OVB_FIFO_DEPTH-1:0] fifo_last_reg;
    logic [FW-1:0]         fifo_head_reg, fifo_tail_reg;

    assign wr_en       = din.valid && din_ready_reg;
    assign occ         = wr_ptr_reg - base_reg;
    assign inflight    = CW'($countones(pipe_valid_reg));
    assign credit_used = inflight + fifo_count_reg;
    // Every issued read already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok   = credit_used < CW'(OVB_FIFO_DEPTH);
    assign issue       = (state_reg == READ) && credit_ok;
    assign frame_end   = issue && (rd_idx_reg == IW'(FRAME_LEN - 1));
    assign rd_ptr      = base_reg + PW'(rd_idx_reg);
    assign wr_ptr_next = wr_ptr_reg + PW'(wr_en);
    assign base_next   = frame_end ? (base_reg + PW'(HOP)) : base_reg;
    assign occ_next    = wr_ptr_next - base_next;

    sdp_ram #(
        .WIDTH     (DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_reg[AW-1:0]),
        .wr_data(din.data),
        .rd_en  (issue),
        .rd_addr(rd_ptr[AW-1:0]),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            din_ready_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            din_ready_reg <= occ_next < PW'(DEPTH);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            rd_idx_reg <= '0;
            base_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (occ >= PW'(FRAME_LEN)) begin
                        state_reg  <= READ;
                        rd_idx_reg <= '0;
                    end
                end
                READ: begin
                    if (frame_end) begin
                        base_reg  <= base_next;
                        state_reg <= IDLE;
                    end else if (issue) begin
                        rd_idx_reg <= rd_idx_reg + IW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign push = pipe_valid_reg[RAM_LATENCY-1];
    assign pop  = dout.valid && dout.ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_reg <= '0;
            pipe_last_reg  <= '0;
            fifo_head_reg  <= '0;
            fifo_tail_reg  <= '0;
            fifo_count_reg <= '0;
        end else begin
            pipe_valid_reg <= {pipe_valid_reg[RAM_LATENCY-2:0], issue};
            pipe_last_reg  <= {pipe_last_reg[RAM_LATENCY-2:0], frame_end};
            if (push) fifo_tail_reg <= fifo_tail_reg + FW'(1);
            if (pop)  fifo_head_reg <= fifo_head_reg + FW'(1);
            fifo_count_reg <= fifo_count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_reg[fifo_tail_reg] <= rd_data;
            fifo_last_reg[fifo_tail_reg] <= pipe_last_reg[RAM_LATENCY-1];
        end
    end

    assign din.ready  = din_ready_reg;
    assign dout.valid = (fifo_count_reg != '0);
    assign dout.data  = fifo_data_reg[fifo_head_reg];
    assign dout_last  = dout.valid && fifo_last_reg[fifo_head_reg];

`ifdef OVERLAP_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop && dout_last && (frame_count != '1)) frame_count <= frame_count + 32'd1;
            if (din.valid && !din_ready_reg && (stall_count != '1)) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule
